// File: rtl/pet_pkg.sv
// pet_pkg: shared loader FSM states, pointer-block defaults and RAM limit for the PET core.
package pet_pkg;
  typedef enum logic [2:0] {IDLE, HDR_LO, HDR_HI, DATA, PTR, DONE} state_t;
  localparam logic [7:0] PTR_BASE_DEF = 8'h2A;
  localparam int PTR_COUNT_DEF = 3;
  localparam logic [15:0] RAM_TOP = 16'h8000;
endpackage

// File: rtl/prg_loader.sv
// prg_loader: streams a PRG image into PET RAM over DMA, then writes the BASIC end pointers.
module prg_loader
  import pet_pkg::*;
#(
  parameter logic [7:0] PTR_BASE = PTR_BASE_DEF,
  parameter int PTR_COUNT = PTR_COUNT_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_din,
  output logic        dma_we,
  output logic        cpu_hold,
  output logic        busy,
  output logic        err
);
  localparam logic [7:0] LAST = 8'(2 * PTR_COUNT - 1);
  state_t state, nxt;
  logic dl_q, pend, rise, start;
  logic [15:0] wr_ptr, end_ptr;
  logic [7:0] idx;
  assign rise = ioctl_download & ~dl_q;
  assign start = rise | pend;
  assign end_ptr = wr_ptr[15] ? RAM_TOP : wr_ptr;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? HDR_LO : IDLE;
      HDR_LO:  nxt = ioctl_wr ? HDR_HI : (ioctl_download ? HDR_LO : DONE);
      HDR_HI:  nxt = ioctl_wr ? DATA : (ioctl_download ? HDR_HI : DONE);
      DATA:    nxt = ioctl_download ? DATA : PTR;
      PTR:     nxt = (idx == LAST) ? DONE : PTR;
      default: nxt = IDLE;
    endcase
  end
  // wr_ptr doubles as the load address while the header is assembled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      dl_q       <= 1'b0;
      pend       <= 1'b0;
      wr_ptr     <= '0;
      idx        <= '0;
      dma_addr   <= '0;
      dma_din    <= '0;
      dma_we     <= 1'b0;
      ioctl_wait <= 1'b0;
      cpu_hold   <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= nxt;
      dl_q       <= ioctl_download;
      dma_we     <= 1'b0;
      busy       <= nxt != IDLE;
      cpu_hold   <= nxt != IDLE;
      ioctl_wait <= nxt == PTR || nxt == DONE;
      pend       <= (state == IDLE) ? 1'b0 : (pend | rise);
      case (state)
        IDLE: if (start) err <= 1'b0;
        HDR_LO: begin
          if (ioctl_wr) wr_ptr[7:0] <= ioctl_dout;
          else if (!ioctl_download) err <= 1'b1;
        end
        HDR_HI: begin
          if (ioctl_wr) wr_ptr[15:8] <= ioctl_dout;
          else if (!ioctl_download) err <= 1'b1;
        end
        DATA: begin
          idx <= '0;
          if (ioctl_wr) begin
            if (wr_ptr[15]) err <= 1'b1;
            else begin
              dma_we   <= 1'b1;
              dma_addr <= wr_ptr;
              dma_din  <= ioctl_dout;
            end
            wr_ptr <= (&wr_ptr) ? wr_ptr : wr_ptr + 16'd1;
          end
        end
        PTR: begin
          dma_we   <= 1'b1;
          dma_addr <= {8'h00, PTR_BASE + idx};
          dma_din  <= idx[0] ? end_ptr[15:8] : end_ptr[7:0];
          idx      <= idx + 8'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/prg_loader.md
PRG_LOADER -- requirements
Module: prg_loader

Interface
REQ-001 Parameter PTR_BASE, default 8'h2A: zero-page address of the first BASIC end pointer (VARTAB).
REQ-002 Parameter PTR_COUNT, default 3: number of consecutive 16-bit pointers written (VARTAB, ARYTAB, STREND).
REQ-003 clk  input  1  system clock; one clock, all logic on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 ioctl_download  input  1  high while a PRG image streams in.
REQ-006 ioctl_wr  input  1  one-cycle strobe, ioctl_dout valid.
REQ-007 ioctl_dout  input  8  image byte.
REQ-008 ioctl_wait  output  1  source stall; no ioctl_wr is issued while high.
REQ-009 dma_addr  output  16  RAM write address to the PET hardware DMA port.
REQ-010 dma_din  output  8  RAM write data.
REQ-011 dma_we  output  1  one-cycle write strobe.
REQ-012 cpu_hold  output  1  holds the CPU in reset while loading.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 err  output  1  sticky error flag (short image or overflow).

Function
REQ-015 States SHALL be IDLE, HDR_LO, HDR_HI, DATA, PTR, DONE.
REQ-016 IDLE->HDR_LO on ioctl_download rising edge; err SHALL clear at the same edge.
REQ-017 HDR_LO: first ioctl_wr byte SHALL load load_addr[7:0] -> HDR_HI; HDR_HI: second byte SHALL load load_addr[15:8] -> DATA; header bytes SHALL generate no dma_we.
REQ-018 DATA: each ioctl_wr SHALL drive dma_addr=wr_ptr, dma_din=byte, dma_we=1 on the next cycle (latency 1), then wr_ptr SHALL increment by 1 (16-bit).
REQ-019 Any data byte with wr_ptr[15]=1 SHALL be dropped (dma_we stays 0), SHALL set err, and SHALL still increment wr_ptr; no write reaches the ROM space.
REQ-020 wr_ptr SHALL saturate at 16'hFFFF rather than wrap to 0.
REQ-021 ioctl_download falling in DATA -> PTR; falling in HDR_LO or HDR_HI SHALL set err -> DONE with no pointer writes.
REQ-022 PTR: end = min(wr_ptr, 16'h8000) SHALL be written as PTR_COUNT little-endian pairs at PTR_BASE, PTR_BASE+1, ..., one byte per cycle, 2*PTR_COUNT consecutive dma_we pulses, low byte first.
REQ-023 DONE SHALL last exactly one cycle, then IDLE.
REQ-024 ioctl_wait SHALL be high in PTR and DONE and low elsewhere; ioctl_wr received while ioctl_wait is high SHALL be ignored.
REQ-025 A rising ioctl_download received while in PTR or DONE SHALL be deferred until IDLE; it SHALL not be lost.
REQ-026 cpu_hold SHALL be high from the ioctl_download rising edge until the cycle after DONE.
REQ-027 dma_we SHALL never be high for more than one cycle per accepted byte or pointer byte; dma_addr and dma_din SHALL hold their last values when dma_we is low.

Reset
REQ-028 While reset_n is low: state=IDLE, dma_addr=0, dma_din=0, dma_we=0, ioctl_wait=0, cpu_hold=0, busy=0, err=0, wr_ptr=0, load_addr=0.
REQ-029 Reset asserted mid-load SHALL abort immediately with no further dma_we; pointers are not written.

Structure
REQ-030 Shared package pet_pkg SHALL hold the state enum, PTR_BASE/PTR_COUNT defaults, and RAM_TOP=16'h8000.
REQ-031 Single module, no sub-modules; the downstream consumer is the PET hardware block DMA port (dma_addr[15]=0 selects RAM).

Verification
REQ-032 Image 01 04 AA BB CC -> dma_we writes AA@0401, BB@0402, CC@0403; then 04@002A, 04@002B, 04@002C, 04@002D, 04@002E, 04@002F; err=0.
REQ-033 Image FE 7F 11 22 33 -> writes 11@7FFE and 22@7FFF; 33 is dropped; err=1; pointers=0x8000.
REQ-034 Single-byte image 01 -> no dma_we at all; err=1; DONE->IDLE; cpu_hold falls.
REQ-035 reset_n low for 1 cycle after the 2nd data byte -> all outputs 0 asynchronously; no pointer writes follow.
REQ-036 New ioctl_download rising during PTR -> pointer writes complete (6 pulses), then the new load starts with err cleared.
REQ-037 Back-to-back ioctl_wr every cycle in DATA -> one dma_we per byte with no gaps or drops; latency 1.
